// File: rtl/sim_run_sequencer.sv
// Simulation run sequencer: holds DUT reset, counts run cycles, collects
// end-of-test conditions and hands one pass/fail report to a consumer.
module sim_run_sequencer #(
  parameter int unsigned NUM_SRC     = 4,
  parameter int unsigned CNT_W       = 64,
  parameter int unsigned HOLD_CYCLES = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [CNT_W-1:0]   max_cycles,
  input  logic [CNT_W-1:0]   dump_start,
  input  logic [NUM_SRC-1:0] pass_mask,
  input  logic [NUM_SRC-1:0] src_success,
  input  logic [NUM_SRC-1:0] src_fail,
  output logic               dut_reset,
  output logic               dump_en,
  output logic [CNT_W-1:0]   cycle_count,
  output logic               finish_valid,
  input  logic               finish_ready,
  output logic               finish_pass,
  output logic [7:0]         finish_code,
  output logic               done
);

  localparam int unsigned HOLD_W       = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [7:0]  CODE_PASS    = 8'h00;
  localparam logic [7:0]  CODE_TIMEOUT = 8'hFF;

  typedef enum logic [1:0] {
    ST_HOLD   = 2'd0,
    ST_RUN    = 2'd1,
    ST_REPORT = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t             state, state_nxt;
  logic [HOLD_W-1:0]  hold_cnt, hold_cnt_nxt;
  logic [NUM_SRC-1:0] succ_seen, succ_seen_nxt;
  logic [CNT_W-1:0]   cycle_count_nxt;
  logic               finish_valid_nxt;
  logic               finish_pass_nxt;
  logic [7:0]         finish_code_nxt;
  logic               done_nxt;
  logic               dut_reset_nxt;
  logic               dump_en_nxt;

  logic [NUM_SRC-1:0] succ_now;
  logic               fail_hit;
  logic               timeout_hit;
  logic               pass_hit;
  logic [7:0]         fail_code;
  logic [CNT_W-1:0]   cycle_inc;

  // End-of-test condition detection, evaluated against the current cycle count
  assign succ_now    = succ_seen | src_success;
  assign fail_hit    = |src_fail;
  assign timeout_hit = (max_cycles != '0) && (cycle_count > max_cycles);
  assign pass_hit    = (pass_mask != '0) && ((succ_now & pass_mask) == pass_mask);
  assign cycle_inc   = (&cycle_count) ? cycle_count : cycle_count + CNT_W'(1);

  // Lowest failing source wins; scanning downward lets the lowest index overwrite
  always_comb begin
    fail_code = '0;
    for (int k = int'(NUM_SRC) - 1; k >= 0; k--) begin
      if (src_fail[k]) fail_code = 8'(k + 1);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state        <= ST_HOLD;
      hold_cnt     <= '0;
      succ_seen    <= '0;
      cycle_count  <= '0;
      finish_valid <= 1'b0;
      finish_pass  <= 1'b0;
      finish_code  <= '0;
      done         <= 1'b0;
      dut_reset    <= 1'b1;
      dump_en      <= (dump_start == '0);
    end else begin
      state        <= state_nxt;
      hold_cnt     <= hold_cnt_nxt;
      succ_seen    <= succ_seen_nxt;
      cycle_count  <= cycle_count_nxt;
      finish_valid <= finish_valid_nxt;
      finish_pass  <= finish_pass_nxt;
      finish_code  <= finish_code_nxt;
      done         <= done_nxt;
      dut_reset    <= dut_reset_nxt;
      dump_en      <= dump_en_nxt;
    end
  end

  always_comb begin
    state_nxt        = state;
    hold_cnt_nxt     = hold_cnt;
    succ_seen_nxt    = succ_seen;
    cycle_count_nxt  = cycle_count;
    finish_valid_nxt = finish_valid;
    finish_pass_nxt  = finish_pass;
    finish_code_nxt  = finish_code;
    done_nxt         = done;

    case (state)
      ST_HOLD: begin
        hold_cnt_nxt = hold_cnt + HOLD_W'(1);
        if (hold_cnt == HOLD_LAST) begin
          state_nxt       = ST_RUN;
          cycle_count_nxt = CNT_W'(1);
        end
      end
      ST_RUN: begin
        succ_seen_nxt = succ_now;
        // The deciding cycle freezes the count at the value it was judged on
        if (fail_hit || timeout_hit || pass_hit) begin
          state_nxt        = ST_REPORT;
          finish_valid_nxt = 1'b1;
          if (fail_hit) begin
            finish_pass_nxt = 1'b0;
            finish_code_nxt = fail_code;
          end else if (timeout_hit) begin
            finish_pass_nxt = 1'b0;
            finish_code_nxt = CODE_TIMEOUT;
          end else begin
            finish_pass_nxt = 1'b1;
            finish_code_nxt = CODE_PASS;
          end
        end else begin
          cycle_count_nxt = cycle_inc;
        end
      end
      ST_REPORT: begin
        if (finish_ready) begin
          state_nxt        = ST_DONE;
          finish_valid_nxt = 1'b0;
          done_nxt         = 1'b1;
        end
      end
      ST_DONE: begin
      end
      default: begin
        state_nxt = ST_HOLD;
      end
    endcase

    dut_reset_nxt = (state_nxt == ST_HOLD);
    dump_en_nxt   = (state_nxt != ST_DONE) &&
                    ((dump_start == '0) || (cycle_count_nxt >= dump_start));
  end

endmodule

// File: tb/tb_sim_run_sequencer.sv
// Directed bench for sim_run_sequencer: hold length, pass/fail/timeout
// reporting, priority, report handshake, dump window and mid-report reset.
module tb_sim_run_sequencer;

  localparam int unsigned NUM_SRC     = 4;
  localparam int unsigned CNT_W       = 64;
  localparam int unsigned HOLD_CYCLES = 16;

  logic               clock;
  logic               reset;
  logic [CNT_W-1:0]   max_cycles;
  logic [CNT_W-1:0]   dump_start;
  logic [NUM_SRC-1:0] pass_mask;
  logic [NUM_SRC-1:0] src_success;
  logic [NUM_SRC-1:0] src_fail;
  logic               dut_reset;
  logic               dump_en;
  logic [CNT_W-1:0]   cycle_count;
  logic               finish_valid;
  logic               finish_ready;
  logic               finish_pass;
  logic [7:0]         finish_code;
  logic               done;

  int n_checks = 0;
  int n_fail   = 0;

  sim_run_sequencer #(
    .NUM_SRC     (NUM_SRC),
    .CNT_W       (CNT_W),
    .HOLD_CYCLES (HOLD_CYCLES)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .max_cycles   (max_cycles),
    .dump_start   (dump_start),
    .pass_mask    (pass_mask),
    .src_success  (src_success),
    .src_fail     (src_fail),
    .dut_reset    (dut_reset),
    .dump_en      (dump_en),
    .cycle_count  (cycle_count),
    .finish_valid (finish_valid),
    .finish_ready (finish_ready),
    .finish_pass  (finish_pass),
    .finish_code  (finish_code),
    .done         (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_count(input logic [63:0] target);
    int n = 0;
    while (cycle_count !== CNT_W'(target) && n < 500) begin
      tick();
      n++;
    end
    chk("reach_count", 64'(cycle_count), target);
  endtask

  task automatic wait_valid();
    int n = 0;
    while (finish_valid !== 1'b1 && n < 500) begin
      tick();
      n++;
    end
    chk("reach_valid", 64'(finish_valid), 64'd1);
  endtask

  task automatic wait_run();
    int n = 0;
    while (dut_reset !== 1'b0 && n < 100) begin
      tick();
      n++;
    end
    chk("reach_run", 64'(dut_reset), 64'd0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  initial begin
    int n_hold;
    reset        = 1'b0;
    max_cycles   = '0;
    dump_start   = '0;
    pass_mask    = 4'b0101;
    src_success  = '0;
    src_fail     = '0;
    finish_ready = 1'b0;

    // Reset state
    tick();
    tick();
    chk("rst_dut_reset", 64'(dut_reset), 64'd1);
    chk("rst_valid", 64'(finish_valid), 64'd0);
    chk("rst_pass", 64'(finish_pass), 64'd0);
    chk("rst_code", 64'(finish_code), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_count", 64'(cycle_count), 64'd0);
    chk("rst_dump_en", 64'(dump_en), 64'd1);

    // Hold length and first RUN count
    reset  = 1'b1;
    n_hold = 0;
    while (dut_reset === 1'b1 && n_hold < 100) begin
      n_hold++;
      tick();
    end
    chk("hold_len", 64'(n_hold), 64'd16);
    chk("run_first_count", 64'(cycle_count), 64'd1);
    chk("run_dump_en", 64'(dump_en), 64'd1);

    // Pass after both masked sources pulse
    wait_count(10);
    src_success = 4'b0001;
    tick();
    src_success = '0;
    chk("pass_not_yet", 64'(finish_valid), 64'd0);
    chk("count_11", 64'(cycle_count), 64'd11);
    wait_count(20);
    src_success = 4'b0100;
    tick();
    src_success = '0;
    chk("pass_valid", 64'(finish_valid), 64'd1);
    chk("pass_pass", 64'(finish_pass), 64'd1);
    chk("pass_code", 64'(finish_code), 64'd0);
    chk("pass_count", 64'(cycle_count), 64'd20);

    // Back-pressure in REPORT, sources ignored
    src_fail = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_valid", 64'(finish_valid), 64'd1);
      chk("stall_code", 64'(finish_code), 64'd0);
      chk("stall_count", 64'(cycle_count), 64'd20);
    end
    src_fail     = '0;
    finish_ready = 1'b1;
    tick();
    finish_ready = 1'b0;
    chk("done_done", 64'(done), 64'd1);
    chk("done_valid", 64'(finish_valid), 64'd0);
    chk("done_dump_en", 64'(dump_en), 64'd0);
    chk("done_pass", 64'(finish_pass), 64'd1);
    src_fail = 4'b0010;
    tick();
    tick();
    src_fail = '0;
    chk("done_sticky", 64'(done), 64'd1);
    chk("done_code_hold", 64'(finish_code), 64'd0);
    chk("done_count_hold", 64'(cycle_count), 64'd20);

    // Timeout
    max_cycles = 64'd50;
    do_reset();
    chk("rst2_code", 64'(finish_code), 64'd0);
    chk("rst2_done", 64'(done), 64'd0);
    wait_run();
    wait_count(50);
    tick();
    chk("to_not_at_50", 64'(finish_valid), 64'd0);
    chk("to_count_51", 64'(cycle_count), 64'd51);
    tick();
    chk("to_valid", 64'(finish_valid), 64'd1);
    chk("to_code", 64'(finish_code), 64'hFF);
    chk("to_pass", 64'(finish_pass), 64'd0);
    chk("to_count", 64'(cycle_count), 64'd51);

    // Fail beats a simultaneous pass; lowest failing source reported
    max_cycles = '0;
    do_reset();
    wait_run();
    wait_count(5);
    src_success = 4'b0101;
    src_fail    = 4'b1010;
    tick();
    src_success = '0;
    src_fail    = '0;
    chk("prio_valid", 64'(finish_valid), 64'd1);
    chk("prio_pass", 64'(finish_pass), 64'd0);
    chk("prio_code", 64'(finish_code), 64'd2);
    chk("prio_count", 64'(cycle_count), 64'd5);

    // Timeout beats a simultaneous pass
    max_cycles = 64'd3;
    do_reset();
    wait_run();
    wait_count(4);
    src_success = 4'b0101;
    tick();
    src_success = '0;
    chk("to_prio_code", 64'(finish_code), 64'hFF);
    chk("to_prio_pass", 64'(finish_pass), 64'd0);

    // Delayed dump window, then reset mid-REPORT
    max_cycles = '0;
    dump_start = 64'd30;
    pass_mask  = 4'b0001;
    do_reset();
    chk("dump_rst", 64'(dump_en), 64'd0);
    wait_run();
    wait_count(29);
    chk("dump_29", 64'(dump_en), 64'd0);
    tick();
    chk("dump_30", 64'(dump_en), 64'd1);
    chk("dump_count", 64'(cycle_count), 64'd30);
    wait_count(40);
    src_success = 4'b0001;
    tick();
    src_success = '0;
    chk("mid_valid", 64'(finish_valid), 64'd1);
    chk("mid_dump_en", 64'(dump_en), 64'd1);
    tick();
    do_reset();
    chk("mid_rst_valid", 64'(finish_valid), 64'd0);
    chk("mid_rst_dut_reset", 64'(dut_reset), 64'd1);
    chk("mid_rst_count", 64'(cycle_count), 64'd0);
    chk("mid_rst_dump_en", 64'(dump_en), 64'd0);
    tick();
    chk("mid_hold_dut_reset", 64'(dut_reset), 64'd1);
    chk("mid_hold_pass", 64'(finish_pass), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sim_run_sequencer.md
SIM_RUN_SEQUENCER -- requirements
Module: sim_run_sequencer

Interface
REQ-001 SHALL have parameter NUM_SRC, default 4, meaning number of end-of-test sources (1..8).
REQ-002 SHALL have parameter CNT_W, default 64, meaning width of the cycle counter and threshold inputs.
REQ-003 SHALL have parameter HOLD_CYCLES, default 16, meaning the number of cycles DUT reset is held after sequencer reset (>=1).
REQ-004 SHALL have port clock, input, 1, system clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous, active-low sequencer reset.
REQ-006 SHALL have port max_cycles, input, CNT_W, timeout threshold; 0 disables the timeout.
REQ-007 SHALL have port dump_start, input, CNT_W, cycle at which dump_en rises; 0 means dump from the start of the hold phase.
REQ-008 SHALL have port pass_mask, input, NUM_SRC, sources whose success is required for a pass.
REQ-009 SHALL have port src_success, input, NUM_SRC, per-source success indication, one cycle or level.
REQ-010 SHALL have port src_fail, input, NUM_SRC, per-source failure indication.
REQ-011 SHALL have port dut_reset, output, 1, active-high reset driven to the DUT.
REQ-012 SHALL have port dump_en, output, 1, waveform dump window enable.
REQ-013 SHALL have port cycle_count, output, CNT_W, number of RUN cycles elapsed.
REQ-014 SHALL have port finish_valid, output, 1, an end-of-test report is available.
REQ-015 SHALL have port finish_ready, input, 1, the consumer accepts the report.
REQ-016 SHALL have port finish_pass, output, 1, report status: 1 = pass.
REQ-017 SHALL have port finish_code, output, 8, report code: 0 = pass; k+1 = source k failed; 8'hFF = timeout.
REQ-018 SHALL have port done, output, 1, sticky indication that the report was accepted.

Function
REQ-019 SHALL implement the states HOLD, RUN, REPORT and DONE.
REQ-020 SHALL keep dut_reset = 1 while in HOLD and dut_reset = 0 while in RUN, REPORT and DONE.
REQ-021 HOLD: SHALL increment hold_cnt every cycle and move to RUN on the cycle after hold_cnt == HOLD_CYCLES-1.
- This gives exactly HOLD_CYCLES cycles of dut_reset = 1.
REQ-022 RUN: SHALL increment cycle_count by 1 every cycle, so it reads 1 in the first RUN cycle.
- cycle_count SHALL saturate at all-ones.
REQ-023 RUN: SHALL set bit k of the sticky register succ_seen when src_success[k] = 1.
- The sampled value used for the pass check SHALL include the current cycle's src_success.
REQ-024 RUN: SHALL raise the fail condition when any bit of src_fail = 1.
- finish_code = index of the lowest set bit + 1.
REQ-025 RUN: SHALL raise the timeout condition when max_cycles != 0 and cycle_count > max_cycles; finish_code = 8'hFF.
REQ-026 RUN: SHALL raise the pass condition when pass_mask != 0 and (succ_seen | src_success) & pass_mask == pass_mask.
- finish_code = 0.
REQ-027 SHALL resolve simultaneous conditions by the priority source fail > timeout > pass.
REQ-028 SHALL capture the winning condition into finish_pass and finish_code and move RUN to REPORT on the next cycle.
- cycle_count SHALL freeze at the value reached in the deciding cycle.
REQ-029 REPORT: SHALL hold finish_valid = 1 with finish_pass, finish_code and cycle_count stable until finish_valid & finish_ready.
- src_success and src_fail SHALL be ignored in REPORT.
REQ-030 SHALL move from REPORT to DONE on the cycle after the handshake.
- In DONE: finish_valid = 0, done = 1.
- Status outputs SHALL hold until reset, and all inputs SHALL be ignored.
REQ-031 SHALL assert dump_en in HOLD, RUN and REPORT when dump_start == 0 or cycle_count >= dump_start.
- dump_en SHALL be 0 in DONE.
REQ-032 SHALL compute all comparisons unsigned at CNT_W bits.

Reset
REQ-033 While reset = 0 at a rising edge, the sequencer SHALL enter HOLD with the following values on the next cycle:
- hold_cnt = 0, cycle_count = 0, succ_seen = 0;
- finish_valid = 0, finish_pass = 0, finish_code = 0, done = 0;
- dut_reset = 1.
REQ-034 Reset asserted in any state, including mid-RUN or mid-REPORT, SHALL discard the pending report and restart the full hold sequence.
REQ-035 dump_en after reset SHALL follow REQ-031 immediately, i.e. 1 when dump_start == 0.

Verification
REQ-036 HOLD_CYCLES = 16, reset released at cycle 0 -> dut_reset = 1 for exactly 16 cycles, then 0; cycle_count = 1 on the first RUN cycle.
REQ-037 pass_mask = 4'b0101; src_success[0] pulses at RUN cycle 10 and src_success[2] at cycle 20 -> finish_valid rises next cycle with pass = 1, code = 0, cycle_count = 20.
REQ-038 max_cycles = 50, no source events -> timeout at cycle_count = 51, code = 8'hFF, pass = 0.
REQ-039 At the same RUN cycle, src_success completes the mask and src_fail = 4'b1010 -> pass = 0, code = 2.
REQ-040 finish_ready held 0 for 5 cycles in REPORT -> outputs stable and cycle_count frozen; after the handshake done = 1 and dump_en = 0.
REQ-041 dump_start = 30 -> dump_en rises in the cycle cycle_count = 30; reset = 0 asserted mid-REPORT -> HOLD restarts, finish_valid = 0, dut_reset = 1.
